// File: rtl/fetch_thread_sched.sv
// fetch_thread_sched
//
// Multithreaded instruction-fetch stage. Keeps one program counter per
// hardware thread, picks one enabled thread per cycle in round-robin order,
// and reads a synchronous instruction memory. The returned instruction is
// presented one cycle later together with the PC and thread it belongs to.
// Redirects from later stages overwrite a thread's PC and squash that
// thread's fetch if it is currently sitting in stage 2.
//
// Ports:
//   clk             - clock, all state updates on the rising edge
//   reset           - synchronous, active-high
//   en              - stage enable; low stalls issue and holds the outputs
//   thread_en       - per-thread fetch enable mask
//   redirect_valid  - PC redirect request
//   redirect_thread - thread being redirected
//   redirect_pc     - new PC for that thread
//   imem_addr       - instruction memory address (combinational)
//   imem_rd_en      - instruction memory read enable (combinational)
//   imem_data       - instruction memory read data, valid one cycle after a read
//   inst_out        - fetched instruction
//   pc_out          - PC of inst_out
//   thread_id_out   - thread of inst_out
//   valid_out       - inst_out/pc_out/thread_id_out describe a live fetch

module fetch_thread_sched #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int THREAD_BITS     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [(1<<THREAD_BITS)-1:0] thread_en,
  input  logic                       redirect_valid,
  input  logic [THREAD_BITS-1:0]     redirect_thread,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  output logic                       imem_rd_en,
  input  logic [31:0]                imem_data,
  output logic [31:0]                inst_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [THREAD_BITS-1:0]     thread_id_out,
  output logic                       valid_out
);

  localparam int NUM_THREADS = 1 << THREAD_BITS;

  logic [INST_ADDR_WIDTH-1:0] pc [NUM_THREADS];
  logic [THREAD_BITS-1:0]     rr_last;
  logic [INST_ADDR_WIDTH-1:0] s2_pc;
  logic [THREAD_BITS-1:0]     s2_thread;
  logic                       s2_valid;

  logic [NUM_THREADS-1:0]     eligible;
  logic [THREAD_BITS-1:0]     sel;
  logic [THREAD_BITS-1:0]     cand;
  logic                       found;
  logic                       issue;

  // A thread being redirected this cycle is taken out of the running so its
  // stale PC is never fetched and the redirect never races an increment.
  always_comb begin
    eligible = thread_en;
    if (redirect_valid) begin
      eligible[redirect_thread] = 1'b0;
    end
  end

  // Round-robin pick: scan rr_last+1, rr_last+2, ... and take the first
  // eligible thread. The final step of the scan lands back on rr_last, so a
  // single eligible thread can issue every cycle.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      cand = rr_last + THREAD_BITS'(i);
      if (!found && eligible[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign issue = en & found;

  // Memory request. When nothing issues the address parks on the last
  // issued thread's PC; it is harmless because the read enable is low.
  always_comb begin
    imem_rd_en = issue;
    imem_addr  = issue ? pc[sel] : pc[rr_last];
  end

  // PC file, round-robin pointer and stage-2 bookkeeping. An issue always
  // refreshes stage 2; with en high and nothing to issue stage 2 goes idle;
  // while stalled everything holds except that a redirect of the thread in
  // stage 2 kills that fetch. The redirect PC write is independent of en.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc[t] <= INST_ADDR_WIDTH'(t << (INST_ADDR_WIDTH - THREAD_BITS));
      end
      rr_last   <= THREAD_BITS'(NUM_THREADS - 1);
      s2_pc     <= '0;
      s2_thread <= '0;
      s2_valid  <= 1'b0;
    end else begin
      if (issue) begin
        pc[sel]   <= pc[sel] + 1'b1;
        rr_last   <= sel;
        s2_pc     <= pc[sel];
        s2_thread <= sel;
        s2_valid  <= 1'b1;
      end else if (en) begin
        s2_valid <= 1'b0;
      end else if (redirect_valid && s2_valid && (s2_thread == redirect_thread)) begin
        s2_valid <= 1'b0;
      end

      if (redirect_valid) begin
        pc[redirect_thread] <= redirect_pc;
      end
    end
  end

  // Stage-2 outputs; the instruction comes straight from the memory, which
  // holds its data whenever no read is issued.
  always_comb begin
    inst_out      = imem_data;
    pc_out        = s2_pc;
    thread_id_out = s2_thread;
    valid_out     = s2_valid;
  end

endmodule

// File: tb/tb_fetch_thread_sched.sv
// tb_fetch_thread_sched
//
// Self-checking bench for fetch_thread_sched. A behavioural model of the
// thread PCs and round-robin order predicts each issue; predicted fetches are
// queued when issued and popped when the stage-2 outputs appear one cycle
// later. Fixed address/thread tables cover the scripted scenarios.

module tb_fetch_thread_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  thread_en;
  logic        redirect_valid;
  logic [1:0]  redirect_thread;
  logic [8:0]  redirect_pc;
  logic [8:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data;
  logic [31:0] inst_out;
  logic [8:0]  pc_out;
  logic [1:0]  thread_id_out;
  logic        valid_out;

  fetch_thread_sched #(
    .INST_ADDR_WIDTH(9),
    .THREAD_BITS(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .thread_en      (thread_en),
    .redirect_valid (redirect_valid),
    .redirect_thread(redirect_thread),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_data      (imem_data),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .thread_id_out  (thread_id_out),
    .valid_out      (valid_out)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Address-dependent instruction pattern so every word is distinguishable.
  function automatic logic [31:0] memWord(input logic [8:0] a);
    return {8'hC3, 7'd0, a, ~a[7:0]};
  endfunction

  // Synchronous instruction memory that holds its data when not read.
  initial imem_data = 32'd0;
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= memWord(imem_addr);
  end

  typedef struct {
    logic [8:0] pc;
    logic [1:0] tid;
  } fetch_t;

  fetch_t      sbq[$];
  int          checks = 0;
  int          errors = 0;

  logic [8:0]  mpc [4];
  logic [1:0]  mrr;
  logic [8:0]  exPc;
  logic [1:0]  exT;
  logic        exV;
  logic [31:0] exInst;
  logic [31:0] issuedAddr;
  logic [31:0] issuedThread;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the stage-2 outputs against the expected held values.
  task automatic checkStage2();
    checkOutput("valid_out", 32'(valid_out), 32'(exV));
    checkOutput("pc_out", 32'(pc_out), 32'(exPc));
    checkOutput("thread_id_out", 32'(thread_id_out), 32'(exT));
    if (exV) checkOutput("inst_out", inst_out, exInst);
  endtask

  // Synchronous reset with arbitrary other inputs; the model returns to its
  // reset state and any queued fetches are discarded.
  task automatic applyReset(input logic e, input logic [3:0] te, input logic rv,
                            input logic [1:0] rt, input logic [8:0] rpc);
    en = e; thread_en = te; redirect_valid = rv; redirect_thread = rt; redirect_pc = rpc;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int t = 0; t < 4; t++) mpc[t] = 9'(t * 128);
    mrr = 2'd3;
    exPc = '0; exT = '0; exV = 1'b0; exInst = '0;
    sbq.delete();
    checkStage2();
  endtask

  // One clock cycle: drive inputs, check the memory request against the
  // model, advance the model, then check stage 2 after the edge.
  task automatic applyStimulus(input logic e, input logic [3:0] te, input logic rv,
                               input logic [1:0] rt, input logic [8:0] rpc);
    logic [3:0] elig;
    logic [1:0] c;
    logic [1:0] mSel;
    logic       mIssue;
    fetch_t     ent;
    en = e; thread_en = te; redirect_valid = rv; redirect_thread = rt; redirect_pc = rpc;
    #1;
    elig = te;
    if (rv) elig[rt] = 1'b0;
    mIssue = 1'b0;
    mSel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      c = mrr + 2'(k);
      if (!mIssue && elig[c]) begin
        mIssue = 1'b1;
        mSel = c;
      end
    end
    mIssue = mIssue & e;
    checkOutput("imem_rd_en", 32'(imem_rd_en), 32'(mIssue));
    issuedAddr = 32'hFFFF_FFFF;
    issuedThread = 32'hFFFF_FFFF;
    if (mIssue) begin
      checkOutput("imem_addr", 32'(imem_addr), 32'(mpc[mSel]));
      issuedAddr = 32'(mpc[mSel]);
      issuedThread = 32'(mSel);
      sbq.push_back('{pc: mpc[mSel], tid: mSel});
      mpc[mSel] = mpc[mSel] + 9'd1;
      mrr = mSel;
    end else if (e) begin
      checkOutput("idle_addr", 32'(imem_addr), 32'(mpc[mrr]));
      exV = 1'b0;
    end else if (rv && exV && exT == rt) begin
      exV = 1'b0;
    end
    if (rv) mpc[rt] = rpc;
    @(posedge clk); #1;
    if (mIssue) begin
      if (sbq.size() == 0) begin
        checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        ent = sbq.pop_front();
        exPc = ent.pc; exT = ent.tid; exV = 1'b1; exInst = memWord(ent.pc);
      end
    end
    checkStage2();
  endtask

  initial begin
    int seqAddr [8];
    seqAddr = '{0, 128, 256, 384, 1, 129, 257, 385};
    reset = 1'b0; en = 1'b0; thread_en = '0;
    redirect_valid = 1'b0; redirect_thread = '0; redirect_pc = '0;
    @(posedge clk); #1;

    // Reset, then full round-robin across all four threads.
    applyReset(1'b1, 4'hF, 1'b0, 2'd0, 9'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 9'd0);
      checkOutput("rr_seq_addr", issuedAddr, 32'(seqAddr[i]));
      checkOutput("rr_seq_tid", issuedThread, 32'(i % 4));
    end

    // Threads 0 and 2 alternate; then no thread enabled.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'b0101, 1'b0, 2'd0, 9'd0);
      checkOutput("alt_tid", issuedThread, (i % 2 == 0) ? 32'd0 : 32'd2);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 9'd0);
      checkOutput("none_issue", issuedAddr, 32'hFFFF_FFFF);
    end

    // PC wrap on thread 1.
    applyStimulus(1'b1, 4'b0010, 1'b1, 2'd1, 9'd511);
    checkOutput("wrap_masked", issuedAddr, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 4'b0010, 1'b0, 2'd0, 9'd0);
    checkOutput("wrap_511", issuedAddr, 32'd511);
    applyStimulus(1'b1, 4'b0010, 1'b0, 2'd0, 9'd0);
    checkOutput("wrap_0", issuedAddr, 32'd0);

    // Three-cycle stall in the middle of a stream.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 9'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hF, 1'b0, 2'd0, 9'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 9'd0);

    // Redirect thread 2 while its fetch is in stage 2, no competing issue.
    applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0, 9'd0);
    checkOutput("t2_issue", issuedThread, 32'd2);
    applyStimulus(1'b1, 4'b0100, 1'b1, 2'd2, 9'h040);
    checkOutput("t2_squash_valid", 32'(valid_out), 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0, 9'd0);
    checkOutput("t2_redirect_pc", issuedAddr, 32'h040);
    // Same squash while stalled.
    applyStimulus(1'b0, 4'b0100, 1'b1, 2'd2, 9'h080);
    checkOutput("stall_squash_valid", 32'(valid_out), 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0, 9'd0);
    checkOutput("stall_redirect_pc", issuedAddr, 32'h080);
    // Redirect with other threads eligible: another thread issues, no squash.
    applyStimulus(1'b1, 4'hF, 1'b1, 2'd2, 9'h040);
    checkOutput("skip_t2_tid", issuedThread, 32'd3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 9'd0);
    checkOutput("t2_after_skip", issuedAddr, 32'h040);

    // Reset during a stall with a pending redirect; redirect is lost.
    applyStimulus(1'b0, 4'hF, 1'b0, 2'd0, 9'd0);
    applyReset(1'b0, 4'hF, 1'b1, 2'd0, 9'h055);
    applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 9'd0);
    checkOutput("post_reset_tid", issuedThread, 32'd0);
    checkOutput("post_reset_addr", issuedAddr, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_thread_sched.md
# fetch_thread_sched

Multithreaded instruction-fetch stage sitting directly upstream of the fetch/decode pipeline register. It holds one program counter per hardware thread, selects a thread each cycle by round-robin over the enabled threads, and drives a synchronous instruction memory. One cycle later it presents the returned instruction together with its PC and thread ID. Redirects from later stages (branches/jumps) overwrite a thread's PC and squash that thread's in-flight fetch.

## Interface
Parameters:
- INST_ADDR_WIDTH, 9, instruction word address width; PCs wrap modulo 2^INST_ADDR_WIDTH.
- THREAD_BITS, 2, thread ID width; NUM_THREADS = 2^THREAD_BITS.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- en  input  1  stage enable; low = stall (no issue, outputs hold).
- thread_en  input  NUM_THREADS  per-thread fetch enable mask.
- redirect_valid  input  1  PC redirect request.
- redirect_thread  input  THREAD_BITS  thread being redirected.
- redirect_pc  input  INST_ADDR_WIDTH  new PC for that thread.
- imem_addr  output  INST_ADDR_WIDTH  instruction memory address (combinational).
- imem_rd_en  output  1  memory read enable (combinational).
- imem_data  input  32  memory read data; valid 1 cycle after a read; held by memory while imem_rd_en=0.
- inst_out  output  32  fetched instruction (= imem_data).
- pc_out  output  INST_ADDR_WIDTH  PC of inst_out.
- thread_id_out  output  THREAD_BITS  thread of inst_out.
- valid_out  output  1  inst_out/pc_out/thread_id_out are a live fetch.

## Operation
- State: pc[t] per thread; rr_last (last issued thread); stage-2 registers s2_pc, s2_thread, s2_valid.
- Reset values: pc[t] = t << (INST_ADDR_WIDTH-THREAD_BITS) (defaults: 0, 128, 256, 384); rr_last = NUM_THREADS-1; s2_pc, s2_thread, s2_valid = 0. After reset, pc_out = 0, thread_id_out = 0, valid_out = 0.
- Eligible mask = thread_en, with bit redirect_thread cleared when redirect_valid=1.
- Selection: the first eligible thread searching rr_last+1, rr_last+2, … cyclically (mod NUM_THREADS). issue = en & (eligible != 0).
- imem_addr = pc[sel] when issue, else pc[rr_last]. imem_rd_en = issue.
- On an issue cycle:
  - pc[sel] <= pc[sel]+1, wrapping.
  - rr_last <= sel.
  - s2_pc <= pc[sel], s2_thread <= sel, s2_valid <= 1.
- en=1 with no eligible thread: s2_valid <= 0; PCs and rr_last hold.
- en=0 (stall): PCs (except redirect), rr_last, s2_pc, s2_thread and s2_valid all hold. Exception: the redirect squash below still applies.
- Redirect, applied regardless of en:
  - pc[redirect_thread] <= redirect_pc.
  - If s2_valid and s2_thread == redirect_thread and no new issue overwrites stage 2 this cycle, then s2_valid <= 0.
- inst_out = imem_data; pc_out = s2_pc; thread_id_out = s2_thread; valid_out = s2_valid.
- Simultaneous events:
  - A redirect never conflicts with an increment, because the redirected thread is masked from selection that cycle.
  - reset overrides everything, including redirect and en.

## Timing
- Issue in cycle N (imem_addr = P, thread T): cycle N+1 shows inst_out = mem[P], pc_out = P, thread_id_out = T, valid_out = 1.
- Throughput: one instruction per cycle while en=1 and any thread is eligible.
- Stall: outputs are stable for every cycle en=0. The memory holds imem_data because imem_rd_en=0.
- Redirect in cycle N: the thread's next fetch uses redirect_pc, at the earliest in cycle N+1.
- Squash: when the redirected thread matches stage 2 and no issue occurs that cycle, valid_out drops in cycle N+1.
- Reset mid-operation: the next cycle shows all reset values and in-flight fetches are discarded. The first issue after reset is thread 0 at PC 0.

## Test plan
- Reset, thread_en=4'b1111, en=1:
  - imem_addr sequence 0, 128, 256, 384, 1, 129, …
  - thread_id_out sequence 0, 1, 2, 3 one cycle later, valid_out=1, pc_out matching.
- thread_en=4'b0101: issue alternates thread 0 / thread 2. Set thread_en=0: valid_out=0 the next cycle and PCs hold.
- PC wrap: redirect thread 1 to 511 with only thread 1 enabled. Fetches occur at 511, then 0.
- Stall: deassert en for 3 cycles mid-stream.
  - imem_rd_en=0 during the stall.
  - pc_out, thread_id_out, valid_out unchanged during the stall.
  - The stream resumes with the next round-robin thread, with no skipped or duplicated PCs.
- Redirect thread 2 to 0x40 while thread 2's fetch is in stage 2:
  - valid_out drops if no issue occurs that cycle.
  - Thread 2 is skipped that cycle.
  - Thread 2's next fetch uses PC 0x40.
- Reset asserted during a stall with pending redirect: outputs return to 0/0/0. The first issue is thread 0 at PC 0 and the redirect is lost.
